mem_arbiter_2p: RTL and testbench
=================================

MEM_ARBITER_2P -- requirements
Module: mem_arbiter_2p

Interface
REQ-001 Parameter BITS_DATA, default 32, word width.
REQ-002 Parameter BITS_ADDR, default 16, word-address width.
REQ-003 clk  in  1  single clock, rising-edge logic; the memory writes on the falling edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req0/req1  in  1  access request from port 0 (fetch) / port 1 (load-store).
REQ-006 we0/we1  in  1  1 = write, 0 = read; valid while reqN is high.
REQ-007 addr0/addr1  in  BITS_ADDR  word address.
REQ-008 wdata0/wdata1  in  BITS_DATA  write data.
REQ-009 gnt0/gnt1  out  1  one-cycle pulse; the request is accepted at the next rising edge.
REQ-010 rvalid0/rvalid1  out  1  one-cycle completion pulse, for reads and writes.
REQ-011 rdata0/rdata1  out  BITS_DATA  read data, valid while rvalidN is high.
REQ-012 mem_address  out  BITS_ADDR  to the memory address input.
REQ-013 mem_data_in  out  BITS_DATA  to the memory write-data input.
REQ-014 mem_write  out  1  to the memory write enable.
REQ-015 mem_data_out  in  BITS_DATA  asynchronous read data from the memory.

Function
REQ-016 The FSM SHALL have three states: IDLE -> ACCESS -> DONE -> IDLE.
REQ-017 IDLE -> ACCESS SHALL occur on an edge where any reqN is high; otherwise the FSM stays in IDLE.
REQ-018 gnt outputs SHALL be combinational.
- Asserted only in IDLE.
- At most one high per cycle.
REQ-019 Winner selection:
- Only one req high: that port wins.
- Both req high: the port not granted last wins.
REQ-020 The last-grant pointer SHALL update only on acceptance.
REQ-021 On acceptance the block SHALL latch port index, we, addr and wdata.
- Requesters hold req/we/addr/wdata stable until gnt.
- Requesters drop or renew req in the cycle after gnt.
REQ-022 In ACCESS, outputs SHALL come from the latched values:
- mem_address = latched addr.
- mem_data_in = latched wdata.
- mem_write = latched we.
- All three stable for the whole cycle, so the falling-edge write lands.
REQ-023 mem_write SHALL be 0 in IDLE and DONE.
REQ-024 mem_address and mem_data_in SHALL hold their last values outside ACCESS.
REQ-025 At the rising edge ending ACCESS, a read SHALL capture mem_data_out into the granted port's rdata.
REQ-026 In DONE, rvalid of the granted port SHALL be high for exactly one cycle.
- The other port's rvalid is 0.
- rdata of the non-granted port holds its previous value.
REQ-027 Timing: request accepted at edge E gives ACCESS in E..E+1, rvalid in E+1..E+2, next grant possible in the cycle after DONE.
- Throughput: one access per 3 cycles.
REQ-028 A request that is high but not granted SHALL wait without being lost.
- Maximum wait with both ports active: one other transaction.
REQ-029 A req deasserted before gnt SHALL be treated as withdrawn, with no side effects.

Reset
REQ-030 rst_n low SHALL immediately force all of the following, regardless of clk:
- State = IDLE.
- mem_write = 0.
- gnt0 = gnt1 = 0.
- rvalid0 = rvalid1 = 0.
- mem_address = 0, mem_data_in = 0, rdata0 = rdata1 = 0.
- Last-grant pointer = port 1, so port 0 wins the first tie.
REQ-031 Reset asserted in ACCESS or DONE SHALL drop the transaction.
- No rvalid is produced.
- No write occurs if rst_n falls before the negative clk edge.
REQ-032 The first grant after rst_n rises SHALL be possible at the first rising edge with req high.

Structure
REQ-033 A shared package mem_arb_pkg SHALL hold:
- The state enum {IDLE, ACCESS, DONE}.
- The default BITS_DATA/BITS_ADDR constants.
- The port-index constants PORT_FETCH = 0, PORT_LS = 1.
REQ-034 Winner selection SHALL live in one sub-module, rr_arbiter2.
- Inputs: req0, req1, last-grant pointer.
- Outputs: one-hot grant.
- Purely combinational.

Verification
All scenarios use the standard preload: memory words 0..7 = 0x00000000, 0x82000000, 0x8A000000, 0x92000000, 0xA2000000, 0xAA000000, 0xB2000000, 0xF8000000.
REQ-035 Port-0 read of addr 5 -> gnt0 in cycle 0, rvalid0 in cycle 2, rdata0 = 0xAA000000.
REQ-036 Port-1 write 0x12345678 to addr 0x0040, then port-1 read of 0x0040 -> rdata1 = 0x12345678; mem_write high only in the write's ACCESS cycle.
REQ-037 req0 and req1 both held high, reads of addr 1 and 2 -> grant order 0,1,0,1 from reset; rdata0 = 0x82000000, rdata1 = 0x8A000000.
REQ-038 rst_n pulsed low during ACCESS of a write of 0xDEADBEEF to addr 3 (before the negative edge) -> no rvalid; a later read of addr 3 returns 0x92000000.
REQ-039 req1 raised then dropped while port 0 is in ACCESS -> no gnt1, no memory access for port 1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Port indices double as the last-grant pointer encoding.
package mem_arb_pkg;

    localparam int DEF_BITS_DATA = 32;
    localparam int DEF_BITS_ADDR = 16;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LS    = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner select, purely combinational (zero latency).
// On a tie the port not named by last_gnt wins; no requests gives no grant.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req0 && req1) begin
            gnt = (last_gnt == PORT_LS) ? 2'b01 : 2'b10;
        end else if (req0) begin
            gnt = 2'b01;
        end else if (req1) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter_2p.sv
// Shares one falling-edge-write memory between fetch and load-store ports; 3-cycle access (grant, ACCESS, DONE).
// A request that is not granted simply waits in IDLE; withdrawn requests leave no trace.
module mem_arbiter_2p
    import mem_arb_pkg::*;
#(
    parameter int BITS_DATA = DEF_BITS_DATA,
    parameter int BITS_ADDR = DEF_BITS_ADDR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0,
    input  logic                 we0,
    input  logic [BITS_ADDR-1:0] addr0,
    input  logic [BITS_DATA-1:0] wdata0,
    input  logic                 req1,
    input  logic                 we1,
    input  logic [BITS_ADDR-1:0] addr1,
    input  logic [BITS_DATA-1:0] wdata1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 rvalid0,
    output logic                 rvalid1,
    output logic [BITS_DATA-1:0] rdata0,
    output logic [BITS_DATA-1:0] rdata1,
    output logic [BITS_ADDR-1:0] mem_address,
    output logic [BITS_DATA-1:0] mem_data_in,
    output logic                 mem_write,
    input  logic [BITS_DATA-1:0] mem_data_out
);

    state_t     state;
    logic       last_gnt;
    logic       lat_port;
    logic       lat_we;
    logic [1:0] arb_gnt;
    logic       in_idle;

    rr_arbiter2 u_rr (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (last_gnt),
        .gnt      (arb_gnt)
    );

    // rst_n gates the grants so they drop immediately, independent of clk.
    assign in_idle = rst_n && (state == IDLE);
    assign gnt0    = in_idle && arb_gnt[0];
    assign gnt1    = in_idle && arb_gnt[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_gnt    <= PORT_LS;
            lat_port    <= PORT_FETCH;
            lat_we      <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_gnt != 2'b00) begin
                        state    <= ACCESS;
                        last_gnt <= arb_gnt[1];
                        lat_port <= arb_gnt[1];
                        if (arb_gnt[1]) begin
                            lat_we      <= we1;
                            mem_write   <= we1;
                            mem_address <= addr1;
                            mem_data_in <= wdata1;
                        end else begin
                            lat_we      <= we0;
                            mem_write   <= we0;
                            mem_address <= addr0;
                            mem_data_in <= wdata0;
                        end
                    end
                end
                ACCESS: begin
                    state     <= DONE;
                    mem_write <= 1'b0;
                    if (lat_port == PORT_LS) begin
                        rvalid1 <= 1'b1;
                        if (!lat_we) rdata1 <= mem_data_out;
                    end else begin
                        rvalid0 <= 1'b1;
                        if (!lat_we) rdata0 <= mem_data_out;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    rvalid0 <= 1'b0;
                    rvalid1 <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    mem_write <= 1'b0;
                    rvalid0   <= 1'b0;
                    rvalid1   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Directed bench for mem_arbiter_2p with a falling-edge-write, async-read memory model.
module tb_mem_arbiter_2p;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, we0, req1, we1;
    logic [15:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [15:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_write;
    logic [31:0] mem_data_out;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:65535];

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_write) mem[mem_address] <= mem_data_in;
    assign mem_data_out = mem[mem_address];

    mem_arbiter_2p dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req0         (req0),
        .we0          (we0),
        .addr0        (addr0),
        .wdata0       (wdata0),
        .req1         (req1),
        .we1          (we1),
        .addr1        (addr1),
        .wdata1       (wdata1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .rvalid0      (rvalid0),
        .rvalid1      (rvalid1),
        .rdata0       (rdata0),
        .rdata1       (rdata1),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_write    (mem_write),
        .mem_data_out (mem_data_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        mem[1] = 32'h82000000; mem[2] = 32'h8A000000; mem[3] = 32'h92000000;
        mem[4] = 32'hA2000000; mem[5] = 32'hAA000000; mem[6] = 32'hB2000000;
        mem[7] = 32'hF8000000;

        rst_n = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 16'h0; wdata0 = 32'h0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 16'h0; wdata1 = 32'h0;
        #2;
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_address", 32'(mem_address), 32'd0);
        chk("rst_mem_data_in", mem_data_in, 32'd0);
        chk("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        req0 = 1'b1;
        #1;
        chk("rst_gnt_masked", 32'({gnt1, gnt0}), 32'd0);
        req0 = 1'b0;
        tick;
        rst_n = 1'b1;

        // Port-0 read of addr 5
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'd5;
        #1;
        chk("s1_gnt", 32'({gnt1, gnt0}), 32'b01);
        tick;
        req0 = 1'b0;
        chk("s1_access_write", 32'(mem_write), 32'd0);
        chk("s1_access_addr", 32'(mem_address), 32'd5);
        chk("s1_access_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        tick;
        chk("s1_done_rvalid", 32'({rvalid1, rvalid0}), 32'b01);
        chk("s1_rdata0", rdata0, 32'hAA000000);
        tick;
        chk("s1_idle_rvalid", 32'({rvalid1, rvalid0}), 32'd0);

        // Port-1 write then read of 0x0040
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0040; wdata1 = 32'h12345678;
        #1;
        chk("s2_wr_gnt", 32'({gnt1, gnt0}), 32'b10);
        tick;
        req1 = 1'b0;
        chk("s2_wr_access_write", 32'(mem_write), 32'd1);
        chk("s2_wr_access_addr", 32'(mem_address), 32'h40);
        chk("s2_wr_access_data", mem_data_in, 32'h12345678);
        tick;
        chk("s2_wr_done_write", 32'(mem_write), 32'd0);
        chk("s2_wr_done_rvalid", 32'({rvalid1, rvalid0}), 32'b10);
        tick;
        chk("s2_wr_idle_write", 32'(mem_write), 32'd0);
        req1 = 1'b1; we1 = 1'b0;
        #1;
        chk("s2_rd_gnt", 32'({gnt1, gnt0}), 32'b10);
        tick;
        req1 = 1'b0;
        chk("s2_rd_access_write", 32'(mem_write), 32'd0);
        tick;
        chk("s2_rd_done_rvalid", 32'({rvalid1, rvalid0}), 32'b10);
        chk("s2_rdata1", rdata1, 32'h12345678);
        tick;

        // Both ports held high from reset: grants alternate 0,1,0,1
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'd1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'd2;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("s3_gnt_%0d", k), 32'({gnt1, gnt0}), (k % 2 == 0) ? 32'b01 : 32'b10);
            tick;
            chk($sformatf("s3_access_nognt_%0d", k), 32'({gnt1, gnt0}), 32'd0);
            tick;
            chk($sformatf("s3_rvalid_%0d", k), 32'({rvalid1, rvalid0}), (k % 2 == 0) ? 32'b01 : 32'b10);
            if (k % 2 == 0) chk($sformatf("s3_rdata0_%0d", k), rdata0, 32'h82000000);
            else begin
                chk($sformatf("s3_rdata1_%0d", k), rdata1, 32'h8A000000);
                chk($sformatf("s3_rdata0_hold_%0d", k), rdata0, 32'h82000000);
            end
            tick;
        end
        req0 = 1'b0; req1 = 1'b0;

        // Reset during ACCESS of a write drops it
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'd3; wdata1 = 32'hDEADBEEF;
        #1;
        chk("s4_gnt", 32'({gnt1, gnt0}), 32'b10);
        tick;
        req1 = 1'b0; we1 = 1'b0;
        chk("s4_access_write", 32'(mem_write), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("s4_rst_write", 32'(mem_write), 32'd0);
        chk("s4_rst_addr", 32'(mem_address), 32'd0);
        #5;
        rst_n = 1'b1;
        tick;
        chk("s4_no_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
        chk("s4_mem3_model", mem[3], 32'h92000000);
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'd3;
        #1;
        chk("s4_rd_gnt", 32'({gnt1, gnt0}), 32'b01);
        tick;
        req0 = 1'b0;
        tick;
        chk("s4_rd_rvalid", 32'({rvalid1, rvalid0}), 32'b01);
        chk("s4_rd_rdata0", rdata0, 32'h92000000);
        tick;

        // req1 raised and withdrawn while port 0 is in ACCESS
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'd7;
        #1;
        chk("s5_gnt0", 32'({gnt1, gnt0}), 32'b01);
        tick;
        req0 = 1'b0;
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'd6; wdata1 = 32'h00000055;
        #1;
        chk("s5_no_gnt1", 32'(gnt1), 32'd0);
        #1;
        req1 = 1'b0; we1 = 1'b0;
        tick;
        chk("s5_done_rvalid", 32'({rvalid1, rvalid0}), 32'b01);
        chk("s5_rdata0", rdata0, 32'hF8000000);
        tick;
        chk("s5_idle_gnt", 32'({gnt1, gnt0}), 32'd0);
        tick;
        chk("s5_addr_hold", 32'(mem_address), 32'd7);
        chk("s5_write_idle", 32'(mem_write), 32'd0);
        chk("s5_rvalid_idle", 32'({rvalid1, rvalid0}), 32'd0);
        chk("s5_mem6_model", mem[6], 32'hB2000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
